// File: rtl/prod_accum_round.sv
// prod_accum_round
//   Accumulates a framed stream of unsigned products (valid/last qualified)
//   into a wide wrapping accumulator. At end of frame the sum is rounded
//   half-up, shifted right by SHIFT and saturated to OUT_W bits. One result
//   pulse per frame carries the value, saturation/overflow flags and the
//   beat count.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-high
//   PROD_IN    unsigned product sample
//   PROD_VLD   PROD_IN valid this cycle
//   PROD_LAST  last beat of frame (only meaningful with PROD_VLD)
//   RES_OUT    rounded, saturated frame sum
//   RES_VLD    one-cycle pulse qualifying RES_OUT/RES_SAT/ACC_OVF/BEAT_CNT
//   RES_SAT    result saturated (out of range or accumulator overflow)
//   ACC_OVF    accumulator wrapped during the frame
//   BEAT_CNT   accepted beats in the frame (saturating)
//   BUSY       frame open (non-last beat seen, LAST not yet seen)
module prod_accum_round #(
    parameter int unsigned PROD_W = 30,
    parameter int unsigned ACC_W  = 36,
    parameter int unsigned SHIFT  = 12,
    parameter int unsigned OUT_W  = 18,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [PROD_W-1:0] PROD_IN,
    input  logic              PROD_VLD,
    input  logic              PROD_LAST,
    output logic [OUT_W-1:0]  RES_OUT,
    output logic              RES_VLD,
    output logic              RES_SAT,
    output logic              ACC_OVF,
    output logic [CNT_W-1:0]  BEAT_CNT,
    output logic              BUSY
);

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic [ACC_W:0] RoundHalf = (ACC_W + 1)'(1) << (SHIFT - 1);
    // Largest value representable in OUT_W bits, at rounded-value width.
    localparam logic [ACC_W:0] OutMax    = {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               s1_vld_q, s1_vld_d;
    logic [ACC_W-1:0]   s1_sum_q, s1_sum_d;
    logic               s1_ovf_q, s1_ovf_d;
    logic [CNT_W-1:0]   s1_cnt_q, s1_cnt_d;

    logic [OUT_W-1:0]   res_out_q, res_out_d;
    logic               res_vld_q, res_vld_d;
    logic               res_sat_q, res_sat_d;
    logic               res_ovf_q, res_ovf_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;

    // Beat datapath: a beat arriving while idle starts from zero.
    logic [ACC_W-1:0]   base_acc;
    logic               base_ovf;
    logic [CNT_W-1:0]   base_cnt;
    logic [ACC_W:0]     beat_sum;
    logic               beat_ovf;
    logic [CNT_W-1:0]   beat_cnt;

    always_comb begin
        base_acc = (state_q == StIdle) ? '0   : acc_q;
        base_ovf = (state_q == StIdle) ? 1'b0 : ovf_q;
        base_cnt = (state_q == StIdle) ? '0   : cnt_q;
        beat_sum = {1'b0, base_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, PROD_IN};
        beat_ovf = base_ovf | beat_sum[ACC_W];
        beat_cnt = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
    end

    // Frame state and stage-1 capture.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        s1_vld_d = 1'b0;
        s1_sum_d = s1_sum_q;
        s1_ovf_d = s1_ovf_q;
        s1_cnt_d = s1_cnt_q;
        if (PROD_VLD) begin
            if (PROD_LAST) begin
                s1_vld_d = 1'b1;
                s1_sum_d = beat_sum[ACC_W-1:0];
                s1_ovf_d = beat_ovf;
                s1_cnt_d = beat_cnt;
                state_d  = StIdle;
            end else begin
                acc_d    = beat_sum[ACC_W-1:0];
                ovf_d    = beat_ovf;
                cnt_d    = beat_cnt;
                state_d  = StAcc;
            end
        end
    end

    // Stage 2: round, shift, saturate. Outputs hold between pulses.
    logic [ACC_W:0] rounded;
    logic           round_sat;

    always_comb begin
        rounded   = ({1'b0, s1_sum_q} + RoundHalf) >> SHIFT;
        round_sat = s1_ovf_q | (rounded > OutMax);
        res_vld_d = s1_vld_q;
        res_out_d = res_out_q;
        res_sat_d = res_sat_q;
        res_ovf_d = res_ovf_q;
        res_cnt_d = res_cnt_q;
        if (s1_vld_q) begin
            res_out_d = round_sat ? '1 : rounded[OUT_W-1:0];
            res_sat_d = round_sat;
            res_ovf_d = s1_ovf_q;
            res_cnt_d = s1_cnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_sum_q  <= '0;
            s1_ovf_q  <= 1'b0;
            s1_cnt_q  <= '0;
            res_out_q <= '0;
            res_vld_q <= 1'b0;
            res_sat_q <= 1'b0;
            res_ovf_q <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_sum_q  <= s1_sum_d;
            s1_ovf_q  <= s1_ovf_d;
            s1_cnt_q  <= s1_cnt_d;
            res_out_q <= res_out_d;
            res_vld_q <= res_vld_d;
            res_sat_q <= res_sat_d;
            res_ovf_q <= res_ovf_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign RES_OUT  = res_out_q;
    assign RES_VLD  = res_vld_q;
    assign RES_SAT  = res_sat_q;
    assign ACC_OVF  = res_ovf_q;
    assign BEAT_CNT = res_cnt_q;
    assign BUSY     = (state_q == StAcc);

endmodule

// File: tb/tb_prod_accum_round.sv
module tb_prod_accum_round;

    localparam int unsigned PROD_W = 30;
    localparam int unsigned ACC_W  = 36;
    localparam int unsigned SHIFT  = 12;
    localparam int unsigned OUT_W  = 18;
    localparam int unsigned CNT_W  = 16;

    localparam logic [PROD_W-1:0] P11950 = 30'd142802500;
    localparam logic [PROD_W-1:0] PMAX   = 30'd1073676289;

    logic              clk = 1'b0;
    logic              rst;
    logic [PROD_W-1:0] prod;
    logic              vld;
    logic              last;
    logic [OUT_W-1:0]  res_out;
    logic              res_vld;
    logic              res_sat;
    logic              acc_ovf;
    logic [CNT_W-1:0]  beat_cnt;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    prod_accum_round #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .PROD_IN  (prod),
        .PROD_VLD (vld),
        .PROD_LAST(last),
        .RES_OUT  (res_out),
        .RES_VLD  (res_vld),
        .RES_SAT  (res_sat),
        .ACC_OVF  (acc_ovf),
        .BEAT_CNT (beat_cnt),
        .BUSY     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [OUT_W-1:0] out;
        logic             sat;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    // Reference: exact frame total with unbounded arithmetic; wrap is implied by
    // the total reaching 2^ACC_W since all terms are non-negative.
    function automatic exp_t ref_frame(input longint unsigned total, input int unsigned beats,
                                       input int due);
        exp_t              e;
        longint unsigned   wrapped;
        longint unsigned   r;
        longint unsigned   cnt_l;
        wrapped = total % (64'd1 << ACC_W);
        r       = (wrapped + (64'd1 << (SHIFT - 1))) / (64'd1 << SHIFT);
        e.due   = due;
        e.ovf   = (total >= (64'd1 << ACC_W));
        e.sat   = e.ovf || (r >= (64'd1 << OUT_W));
        e.out   = e.sat ? {OUT_W{1'b1}} : r[OUT_W-1:0];
        cnt_l   = (beats >= (1 << CNT_W)) ? (64'd1 << CNT_W) - 1 : 64'(beats);
        e.cnt   = cnt_l[CNT_W-1:0];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic drive(input logic v, input logic l, input logic [PROD_W-1:0] p);
        vld  = v;
        last = l;
        prod = p;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        rst = 1'b0;
        checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %0b want 0", res_vld); end
        checks++; if (res_out !== '0) begin failures++; $display("FAIL reset_out: got %0d want 0", res_out); end
        checks++; if (res_sat !== 1'b0) begin failures++; $display("FAIL reset_sat: got %0b want 0", res_sat); end
        checks++; if (acc_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b want 0", acc_ovf); end
        checks++; if (beat_cnt !== '0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", beat_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    endtask

    task automatic test_single_beat();
        drive(1'b1, 1'b1, P11950);
        checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL single_early_vld: got %0b want 0", res_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %0b want 0", busy); end
        drive(1'b0, 1'b0, '0);
        checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL single_vld: got %0b want 1", res_vld); end
        checks++; if (res_out !== 18'd34864) begin failures++; $display("FAIL single_out: got %0d want 34864", res_out); end
        checks++; if (res_sat !== 1'b0) begin failures++; $display("FAIL single_sat: got %0b want 0", res_sat); end
        checks++; if (acc_ovf !== 1'b0) begin failures++; $display("FAIL single_ovf: got %0b want 0", acc_ovf); end
        checks++; if (beat_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt: got %0d want 1", beat_cnt); end
        drive(1'b0, 1'b0, '0);
        checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL single_pulse_len: got %0b want 0", res_vld); end
        checks++; if (res_out !== 18'd34864) begin failures++; $display("FAIL single_hold: got %0d want 34864", res_out); end
    endtask

    task automatic test_gapped_frame();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 3), P11950);
            checks++;
            if (busy !== (i != 3)) begin
                failures++; $display("FAIL gap_busy_beat%0d: got %0b want %0b", i, busy, (i != 3));
            end
            if (i != 3) begin
                drive(1'b0, 1'b0, '0);
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gap_busy_gap%0d: got %0b want 1", i, busy); end
            end
        end
        drive(1'b0, 1'b0, '0);
        checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL gap_vld: got %0b want 1", res_vld); end
        checks++; if (res_out !== 18'd139456) begin failures++; $display("FAIL gap_out: got %0d want 139456", res_out); end
        checks++; if (beat_cnt !== 16'd4) begin failures++; $display("FAIL gap_cnt: got %0d want 4", beat_cnt); end
    endtask

    task automatic test_rounding();
        drive(1'b1, 1'b1, 30'd2047);
        drive(1'b1, 1'b1, 30'd2048);
        checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL round_lo_vld: got %0b want 1", res_vld); end
        checks++; if (res_out !== 18'd0) begin failures++; $display("FAIL round_lo_out: got %0d want 0", res_out); end
        drive(1'b0, 1'b0, '0);
        checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL round_tie_vld: got %0b want 1", res_vld); end
        checks++; if (res_out !== 18'd1) begin failures++; $display("FAIL round_tie_out: got %0d want 1", res_out); end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_range_sat();
        for (int i = 0; i < 8; i++) drive(1'b1, (i == 7), PMAX);
        drive(1'b0, 1'b0, '0);
        checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL rsat_vld: got %0b want 1", res_vld); end
        checks++; if (res_out !== 18'h3FFFF) begin failures++; $display("FAIL rsat_out: got %0h want 3ffff", res_out); end
        checks++; if (res_sat !== 1'b1) begin failures++; $display("FAIL rsat_sat: got %0b want 1", res_sat); end
        checks++; if (acc_ovf !== 1'b0) begin failures++; $display("FAIL rsat_ovf: got %0b want 0", acc_ovf); end
        checks++; if (beat_cnt !== 16'd8) begin failures++; $display("FAIL rsat_cnt: got %0d want 8", beat_cnt); end
    endtask

    task automatic test_acc_overflow();
        for (int i = 0; i < 65; i++) drive(1'b1, (i == 64), PMAX);
        drive(1'b1, 1'b1, 30'd4096);
        checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL ovf_vld: got %0b want 1", res_vld); end
        checks++; if (acc_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b want 1", acc_ovf); end
        checks++; if (res_sat !== 1'b1) begin failures++; $display("FAIL ovf_sat: got %0b want 1", res_sat); end
        checks++; if (res_out !== 18'h3FFFF) begin failures++; $display("FAIL ovf_out: got %0h want 3ffff", res_out); end
        checks++; if (beat_cnt !== 16'd65) begin failures++; $display("FAIL ovf_cnt: got %0d want 65", beat_cnt); end
        drive(1'b0, 1'b0, '0);
        checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL ovf_next_vld: got %0b want 1", res_vld); end
        checks++; if (res_out !== 18'd1) begin failures++; $display("FAIL ovf_next_out: got %0d want 1", res_out); end
        checks++; if (acc_ovf !== 1'b0) begin failures++; $display("FAIL ovf_next_flag: got %0b want 0", acc_ovf); end
        checks++; if (res_sat !== 1'b0) begin failures++; $display("FAIL ovf_next_sat: got %0b want 0", res_sat); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, P11950);
        drive(1'b1, 1'b1, P11950);
        // Reset lands with the result in flight and a competing LAST beat.
        rst = 1'b1;
        drive(1'b1, 1'b1, 30'd4096);
        rst = 1'b0;
        checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL rmid_vld: got %0b want 0", res_vld); end
        checks++; if (res_out !== '0) begin failures++; $display("FAIL rmid_out: got %0d want 0", res_out); end
        checks++; if (beat_cnt !== '0) begin failures++; $display("FAIL rmid_cnt: got %0d want 0", beat_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        drive(1'b0, 1'b0, '0);
        checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL rmid_late_vld: got %0b want 0", res_vld); end
        drive(1'b1, 1'b1, 30'd4096);
        drive(1'b0, 1'b0, '0);
        checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL rmid_next_vld: got %0b want 1", res_vld); end
        checks++; if (res_out !== 18'd1) begin failures++; $display("FAIL rmid_next_out: got %0d want 1", res_out); end
        checks++; if (beat_cnt !== 16'd1) begin failures++; $display("FAIL rmid_next_cnt: got %0d want 1", beat_cnt); end
    endtask

    // Random frames, gaps and back-to-back LASTs checked cycle by cycle.
    task automatic test_random_frames();
        exp_t              q[$];
        exp_t              e;
        longint unsigned   total = 0;
        int unsigned       beats = 0;
        bit                open  = 0;
        logic [OUT_W-1:0]  h_out = '0;
        logic              h_sat = 1'b0;
        logic              h_ovf = 1'b0;
        logic [CNT_W-1:0]  h_cnt = '0;
        logic              v, l, exp_v;
        logic [PROD_W-1:0] p;
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        rst = 1'b0;
        for (int c = 0; c < 604; c++) begin
            v = (c < 600) && ($urandom_range(0, 3) != 0);
            l = v && ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       p = PROD_W'($urandom);
                1:       p = PMAX;
                2:       p = PROD_W'($urandom_range(0, 8191));
                default: p = PROD_W'(($urandom_range(0, 100) << 12) + 2047 + $urandom_range(0, 2));
            endcase
            if (v) begin
                if (!open) begin
                    total = 0;
                    beats = 0;
                end
                total += 64'(p);
                beats++;
                if (l) begin
                    q.push_back(ref_frame(total, beats, edge_n + 2));
                    open = 0;
                end else begin
                    open = 1;
                end
            end
            drive(v, l, p);
            exp_v = (q.size() > 0) && (q[0].due == edge_n);
            if (exp_v) begin
                e = q.pop_front();
                h_out = e.out;
                h_sat = e.sat;
                h_ovf = e.ovf;
                h_cnt = e.cnt;
            end
            checks++; if (res_vld !== exp_v) begin failures++; $display("FAIL rnd_vld c%0d: got %0b want %0b", c, res_vld, exp_v); end
            checks++; if (res_out !== h_out) begin failures++; $display("FAIL rnd_out c%0d: got %0d want %0d", c, res_out, h_out); end
            checks++; if (res_sat !== h_sat) begin failures++; $display("FAIL rnd_sat c%0d: got %0b want %0b", c, res_sat, h_sat); end
            checks++; if (acc_ovf !== h_ovf) begin failures++; $display("FAIL rnd_ovf c%0d: got %0b want %0b", c, acc_ovf, h_ovf); end
            checks++; if (beat_cnt !== h_cnt) begin failures++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, beat_cnt, h_cnt); end
            checks++; if (busy !== open) begin failures++; $display("FAIL rnd_busy c%0d: got %0b want %0b", c, busy, open); end
        end
        checks++;
        if (q.size() != 0) begin
            failures++; $display("FAIL rnd_drain: got %0d pending results want 0", q.size());
        end
    endtask

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        last = 1'b0;
        prod = '0;
        test_reset();
        test_single_beat();
        test_gapped_frame();
        test_rounding();
        test_range_sat();
        test_acc_overflow();
        test_reset_mid();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
